// File: rtl/min_gen.sv
// Seconds/minutes timekeeper feeding hour_gen: counts sec_tic into sec/min, pulses
// min_tic on each run-mode minute wrap, and lets a push button advance minutes in set mode.
module min_gen #(
  parameter int P_SEC_BIT    = 6,
  parameter int P_MIN_BIT    = 6,
  parameter int P_RPT_DELAY  = 50000000,
  parameter int P_RPT_PERIOD = 10000000,
  parameter int P_CNT_BIT    = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 reset_m,
  input  logic                 reset_all,
  input  logic                 sec_tic,
  input  logic                 set_en,
  input  logic                 inc_btn,
  output logic [P_SEC_BIT-1:0] sec,
  output logic [P_MIN_BIT-1:0] min,
  output logic                 min_tic
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  localparam logic [P_SEC_BIT-1:0] SEC_LAST    = P_SEC_BIT'(59);
  localparam logic [P_MIN_BIT-1:0] MIN_LAST    = P_MIN_BIT'(59);
  localparam logic [P_CNT_BIT-1:0] DELAY_LAST  = P_CNT_BIT'(P_RPT_DELAY - 1);
  localparam logic [P_CNT_BIT-1:0] PERIOD_LAST = P_CNT_BIT'(P_RPT_PERIOD - 1);

  function automatic logic [P_MIN_BIT-1:0] min_step(input logic [P_MIN_BIT-1:0] m);
    return (m == MIN_LAST) ? '0 : m + P_MIN_BIT'(1);
  endfunction

  function automatic logic [P_SEC_BIT-1:0] sec_step(input logic [P_SEC_BIT-1:0] s);
    return (s == SEC_LAST) ? '0 : s + P_SEC_BIT'(1);
  endfunction

  logic                 btn_meta;
  logic                 btn_s;
  btn_state_t           state;
  btn_state_t           state_nxt;
  logic [P_CNT_BIT-1:0] rpt_cnt;
  logic [P_CNT_BIT-1:0] rpt_cnt_nxt;
  logic                 inc;
  logic [P_SEC_BIT-1:0] sec_nxt;
  logic [P_MIN_BIT-1:0] min_nxt;
  logic                 min_tic_nxt;
  logic                 sec_wrap;

  // Button synchronizer: runs in every mode so btn_s is already settled on entering set mode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= inc_btn;
      btn_s    <= btn_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rpt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    inc         = 1'b0;
    if (reset_all || !set_en) begin
      state_nxt   = IDLE;
      rpt_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            inc         = 1'b1;
            rpt_cnt_nxt = '0;
            state_nxt   = DELAY;
          end
        end
        DELAY: begin
          if (!btn_s) begin
            state_nxt   = IDLE;
            rpt_cnt_nxt = '0;
          end else if (rpt_cnt == DELAY_LAST) begin
            inc         = 1'b1;
            rpt_cnt_nxt = '0;
            state_nxt   = REPEAT;
          end else begin
            rpt_cnt_nxt = rpt_cnt + P_CNT_BIT'(1);
          end
        end
        REPEAT: begin
          if (!btn_s) begin
            state_nxt   = IDLE;
            rpt_cnt_nxt = '0;
          end else if (rpt_cnt == PERIOD_LAST) begin
            inc         = 1'b1;
            rpt_cnt_nxt = '0;
          end else begin
            rpt_cnt_nxt = rpt_cnt + P_CNT_BIT'(1);
          end
        end
        default: begin
          state_nxt   = IDLE;
          rpt_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign sec_wrap = sec_tic && (sec == SEC_LAST);

  // Time counters: reset_all > reset_m > set mode > run; set mode swallows any pending wrap
  always_comb begin
    sec_nxt     = sec;
    min_nxt     = min;
    min_tic_nxt = 1'b0;
    if (reset_all) begin
      sec_nxt = '0;
      min_nxt = '0;
    end else begin
      if (set_en) begin
        sec_nxt = '0;
      end else if (sec_tic) begin
        sec_nxt = sec_step(sec);
      end

      if (reset_m) begin
        min_nxt = '0;
      end else if (set_en) begin
        if (inc) begin
          min_nxt = min_step(min);
        end
      end else if (sec_wrap) begin
        min_nxt     = min_step(min);
        min_tic_nxt = (min == MIN_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec     <= '0;
      min     <= '0;
      min_tic <= 1'b0;
    end else begin
      sec     <= sec_nxt;
      min     <= min_nxt;
      min_tic <= min_tic_nxt;
    end
  end

endmodule

// File: tb/tb_min_gen.sv
// Scoreboard bench for min_gen: stimulus queues expected sec/min/min_tic per cycle,
// a negedge monitor pops and compares.
module tb_min_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       reset_m;
  logic       reset_all;
  logic       sec_tic;
  logic       set_en;
  logic       inc_btn;
  logic [5:0] sec;
  logic [5:0] min;
  logic       min_tic;

  min_gen #(
    .P_SEC_BIT   (6),
    .P_MIN_BIT   (6),
    .P_RPT_DELAY (20),
    .P_RPT_PERIOD(5),
    .P_CNT_BIT   (32)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .reset_m  (reset_m),
    .reset_all(reset_all),
    .sec_tic  (sec_tic),
    .set_en   (set_en),
    .inc_btn  (inc_btn),
    .sec      (sec),
    .min      (min),
    .min_tic  (min_tic)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    string name;
    int    s;
    int    m;
    int    t;
  } exp_t;

  exp_t q[$];
  int   cyc        = 0;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   tic_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every queued expectation that falls due on this cycle
  always @(negedge clk) begin
    if (min_tic === 1'b1) tic_pulses++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else if (sec !== 6'(e.s) || min !== 6'(e.m) || min_tic !== 1'(e.t)) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got sec=%0d min=%0d min_tic=%0b, expected sec=%0d min=%0d min_tic=%0d",
                 e.name, cyc, sec, min, min_tic, e.s, e.m, e.t);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input int s, input int m, input int t);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.s    = s;
    e.m    = m;
    e.t    = t;
    q.push_back(e);
  endtask

  task automatic tics(input int n);
    sec_tic = 1'b1;
    repeat (n) tick();
    sec_tic = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int inc_edges[7];
    int n;
    inc_edges = '{2, 22, 27, 32, 37, 42, 47};
    reset_n = 1'b0; reset_m = 1'b0; reset_all = 1'b0;
    sec_tic = 1'b0; set_en  = 1'b0; inc_btn   = 1'b0;

    // Reset state, then count to 12:37 and drop reset_n between clock edges
    repeat (3) tick();
    expect_now("reset_hold", 0, 0, 0);
    reset_n = 1'b1;
    tick();
    expect_now("after_reset", 0, 0, 0);
    tics(757);
    expect_now("count_12_37", 37, 12, 0);
    tick();
    #1 reset_n = 1'b0;
    expect_now("async_reset", 0, 0, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Minute wrap: 59:58 -> 59:59 -> 00:00 with a single-cycle min_tic
    tics(3598);
    expect_now("pre_wrap", 58, 59, 0);
    tics(1);
    expect_now("sec_59", 59, 59, 0);
    tics(1);
    expect_now("wrap_tic", 0, 0, 1);
    tick();
    expect_now("tic_one_cycle", 0, 0, 0);

    // Set mode entered on the very edge that would wrap
    tics(3599);
    expect_now("pre_mode_sw", 59, 59, 0);
    set_en  = 1'b1;
    sec_tic = 1'b1;
    tick();
    sec_tic = 1'b0;
    expect_now("mode_sw", 0, 59, 0);
    tick();
    expect_now("mode_hold", 0, 59, 0);

    // Single press from 59 (manual wrap, no min_tic), sec_tic ignored in set mode
    inc_btn = 1'b1;
    sec_tic = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_now("press", 0, (i >= 2) ? 0 : 59, 0);
    end
    inc_btn = 1'b0;
    repeat (4) tick();
    expect_now("press_settle", 0, 0, 0);
    sec_tic = 1'b0;
    set_en  = 1'b0;
    tick();
    expect_now("run_resume", 0, 0, 0);
    tics(1);
    expect_now("run_first_tic", 1, 0, 0);

    // reset_all beats a wrap, reset_m clears minutes while seconds advance
    tics(3598);
    expect_now("pre_rst_all", 59, 59, 0);
    reset_all = 1'b1;
    sec_tic   = 1'b1;
    tick();
    reset_all = 1'b0;
    sec_tic   = 1'b0;
    expect_now("rst_all", 0, 0, 0);
    tics(70);
    expect_now("pre_rst_m", 10, 1, 0);
    reset_m = 1'b1;
    sec_tic = 1'b1;
    tick();
    reset_m = 1'b0;
    sec_tic = 1'b0;
    expect_now("rst_m", 11, 0, 0);

    // Auto-repeat from 58: increments at edges 2,22,27,32,37,42,47
    tics(3469);
    expect_now("pre_repeat", 0, 58, 0);
    set_en = 1'b1;
    tick();
    expect_now("repeat_entry", 0, 58, 0);
    inc_btn = 1'b1;
    for (int i = 0; i < 56; i++) begin
      tick();
      n = 0;
      for (int k = 0; k < 7; k++) if (i >= inc_edges[k]) n++;
      expect_now("repeat", 0, (58 + n) % 60, 0);
      if (i == 49) inc_btn = 1'b0;
    end
    set_en = 1'b0;

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations never checked, expected 0", q.size());
    end
    n_checks++;
    if (tic_pulses != 1) begin
      n_fail++;
      $display("FAIL min_tic_count: got %0d pulses, expected 1", tic_pulses);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
